// File: rtl/zion_rmw_write_ctrl.sv
// Read-modify-write controller for a single-port memory without byte enables.
// Full masks write directly, empty masks are dropped, partial masks read, merge and write back.
module zion_rmw_write_ctrl #(
    parameter int WIDTH_ADDR = 32,
    parameter int WIDTH_DATA = 32,
    parameter bit MASK_FLAG  = 1'b0,
    parameter int RD_LATENCY = 1
) (
    input  logic                  iClk,
    input  logic                  iRst,
    input  logic                  iReqVld,
    output logic                  oReqRdy,
    input  logic [WIDTH_ADDR-1:0] iReqAddr,
    input  logic [WIDTH_DATA-1:0] iReqDat,
    input  logic [WIDTH_DATA-1:0] iReqMask,
    output logic                  oMemEn,
    output logic                  oMemWe,
    output logic [WIDTH_ADDR-1:0] oMemAddr,
    output logic [WIDTH_DATA-1:0] oMemWDat,
    input  logic [WIDTH_DATA-1:0] iMemRDat,
    output logic                  oBusy,
    output logic                  oDone
);

    if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_rd_latency
        $fatal(1, "zion_rmw_write_ctrl: RD_LATENCY must be in 1..4");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WAIT,
        S_WR,
        S_SKIP
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [WIDTH_ADDR-1:0] r_addr;
    logic [WIDTH_DATA-1:0] r_dat;
    logic [WIDTH_DATA-1:0] r_mask;
    logic [WIDTH_DATA-1:0] r_merged;
    logic [1:0]            r_cnt;
    logic                  w_acc;
    logic [WIDTH_DATA-1:0] w_mask_eff;
    logic                  w_mask_full;

    function automatic logic [WIDTH_DATA-1:0] merge_bits(
        input logic [WIDTH_DATA-1:0] rd,
        input logic [WIDTH_DATA-1:0] wd,
        input logic [WIDTH_DATA-1:0] m
    );
        return (rd & ~m) | (wd & m);
    endfunction

    // Normalise polarity once so everything downstream sees 1 = write this bit.
    assign w_mask_eff  = MASK_FLAG ? ~iReqMask : iReqMask;
    assign oReqRdy     = (r_state == S_IDLE) && !iRst;
    assign w_acc       = iReqVld && oReqRdy;
    assign oBusy       = (r_state != S_IDLE);
    assign w_mask_full = &r_mask;

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_dat    <= '0;
            r_mask   <= '0;
            r_merged <= '0;
            r_cnt    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_acc) begin
                r_addr <= iReqAddr;
                r_dat  <= iReqDat;
                r_mask <= w_mask_eff;
            end
            if (r_state == S_RD) begin
                r_cnt <= 2'(RD_LATENCY - 1);
            end else if (r_state == S_WAIT && r_cnt != 2'd0) begin
                r_cnt <= r_cnt - 2'd1;
            end
            // Read data is only guaranteed valid in the last WAIT cycle.
            if (r_state == S_WAIT && r_cnt == 2'd0) begin
                r_merged <= merge_bits(iMemRDat, r_dat, r_mask);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        oMemEn      = 1'b0;
        oMemWe      = 1'b0;
        oMemAddr    = '0;
        oMemWDat    = '0;
        oDone       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_acc) begin
                    if (&w_mask_eff) begin
                        w_state_nxt = S_WR;
                    end else if (w_mask_eff == '0) begin
                        w_state_nxt = S_SKIP;
                    end else begin
                        w_state_nxt = S_RD;
                    end
                end
            end
            S_RD: begin
                oMemEn      = 1'b1;
                oMemAddr    = r_addr;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (r_cnt == 2'd0) begin
                    w_state_nxt = S_WR;
                end
            end
            S_WR: begin
                oMemEn      = 1'b1;
                oMemWe      = 1'b1;
                oMemAddr    = r_addr;
                oMemWDat    = w_mask_full ? r_dat : r_merged;
                oDone       = 1'b1;
                w_state_nxt = S_IDLE;
            end
            S_SKIP: begin
                oDone       = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_zion_rmw_write_ctrl.sv
// Scoreboard bench for zion_rmw_write_ctrl: two instances (MASK_FLAG=0/RD_LATENCY=1
// and MASK_FLAG=1/RD_LATENCY=3), each with a small behavioural memory.
`timescale 1ns/1ps
module tb_zion_rmw_write_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        vld   [2];
    logic [31:0] raddr [2];
    logic [31:0] rdat  [2];
    logic [31:0] rmask [2];
    logic        rdy   [2];
    logic        men   [2];
    logic        mwe   [2];
    logic [31:0] maddr [2];
    logic [31:0] mwdat [2];
    logic [31:0] mrdat [2];
    logic        busy  [2];
    logic        done  [2];

    zion_rmw_write_ctrl #(.WIDTH_ADDR(32), .WIDTH_DATA(32), .MASK_FLAG(1'b0), .RD_LATENCY(1)) u0 (
        .iClk(clk), .iRst(rst), .iReqVld(vld[0]), .oReqRdy(rdy[0]),
        .iReqAddr(raddr[0]), .iReqDat(rdat[0]), .iReqMask(rmask[0]),
        .oMemEn(men[0]), .oMemWe(mwe[0]), .oMemAddr(maddr[0]), .oMemWDat(mwdat[0]),
        .iMemRDat(mrdat[0]), .oBusy(busy[0]), .oDone(done[0])
    );

    zion_rmw_write_ctrl #(.WIDTH_ADDR(32), .WIDTH_DATA(32), .MASK_FLAG(1'b1), .RD_LATENCY(3)) u1 (
        .iClk(clk), .iRst(rst), .iReqVld(vld[1]), .oReqRdy(rdy[1]),
        .iReqAddr(raddr[1]), .iReqDat(rdat[1]), .iReqMask(rmask[1]),
        .oMemEn(men[1]), .oMemWe(mwe[1]), .oMemAddr(maddr[1]), .oMemWDat(mwdat[1]),
        .iMemRDat(mrdat[1]), .oBusy(busy[1]), .oDone(done[1])
    );

    // Behavioural memories: read data appears RD_LATENCY cycles after the read strobe.
    logic [31:0] mem0 [16];
    logic [31:0] mem1 [16];
    logic        loaded = 1'b0;
    logic        rv0;
    logic [3:0]  ra0;
    logic [2:0]  rv1;
    logic [3:0]  ra1 [3];

    always @(posedge clk) begin
        if (!loaded) begin
            for (int k = 0; k < 16; k++) begin
                mem0[k] <= 32'hA000_0000 | 32'(k);
                mem1[k] <= 32'hB000_0000 | 32'(k);
            end
            mem0[3] <= 32'h1122_3344;
            mem0[2] <= 32'h5566_7788;
            mem0[6] <= 32'h0F0F_0F0F;
            mem1[9] <= 32'hCAFE_0000;
            loaded  <= 1'b1;
        end else begin
            if (men[0] && mwe[0]) mem0[maddr[0][3:0]] <= mwdat[0];
            if (men[1] && mwe[1]) mem1[maddr[1][3:0]] <= mwdat[1];
        end
        rv0    <= men[0] && !mwe[0];
        ra0    <= maddr[0][3:0];
        rv1    <= {rv1[1:0], men[1] && !mwe[1]};
        ra1[0] <= maddr[1][3:0];
        ra1[1] <= ra1[0];
        ra1[2] <= ra1[1];
    end

    assign mrdat[0] = rv0    ? mem0[ra0]    : 32'hDEAD_DEAD;
    assign mrdat[1] = rv1[2] ? mem1[ra1[2]] : 32'hDEAD_DEAD;

    typedef struct {
        int          inst;
        int          cyc;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdat;
    } ev_t;

    ev_t q_acc[$];
    ev_t q_mem[$];
    ev_t q_done[$];
    ev_t me;
    int  n_chk  = 0;
    int  n_pass = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h required 0x%08h (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic check1(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b required %b (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic unexpected(input string nm, input int i);
        n_chk++;
        $display("FAIL %s: event on u%0d at cycle %0d, required none", nm, i, cyc);
    endtask

    task automatic exp_acc(input int i, input int c);
        ev_t e;
        e = '{inst: i, cyc: c, we: 1'b0, addr: 32'h0, wdat: 32'h0};
        q_acc.push_back(e);
    endtask

    task automatic exp_mem(input int i, input int c, input logic we, input logic [31:0] a, input logic [31:0] d);
        ev_t e;
        e = '{inst: i, cyc: c, we: we, addr: a, wdat: d};
        q_mem.push_back(e);
    endtask

    task automatic exp_done(input int i, input int c);
        ev_t e;
        e = '{inst: i, cyc: c, we: 1'b0, addr: 32'h0, wdat: 32'h0};
        q_done.push_back(e);
    endtask

    // Monitor: every accept, memory strobe and done pulse must match the next expectation.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (vld[i] && rdy[i]) begin
                if (q_acc.size() == 0) unexpected("accept", i);
                else begin
                    me = q_acc.pop_front();
                    check("acc_inst", 32'(i), 32'(me.inst));
                    check("acc_cycle", 32'(cyc), 32'(me.cyc));
                end
            end
            if (men[i]) begin
                if (q_mem.size() == 0) unexpected("mem_access", i);
                else begin
                    me = q_mem.pop_front();
                    check("mem_inst", 32'(i), 32'(me.inst));
                    check("mem_cycle", 32'(cyc), 32'(me.cyc));
                    check1("mem_we", mwe[i], me.we);
                    check("mem_addr", maddr[i], me.addr);
                    check("mem_wdat", mwdat[i], me.wdat);
                end
            end else begin
                check("idle_bus_addr", maddr[i], 32'h0);
                check("idle_bus_wdat", mwdat[i], 32'h0);
            end
            if (done[i]) begin
                if (q_done.size() == 0) unexpected("done", i);
                else begin
                    me = q_done.pop_front();
                    check("done_inst", 32'(i), 32'(me.inst));
                    check("done_cycle", 32'(cyc), 32'(me.cyc));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [31:0] a, input logic [31:0] d, input logic [31:0] m);
        vld[i]   = v;
        raddr[i] = a;
        rdat[i]  = d;
        rmask[i] = m;
    endtask

    task automatic send(input int i, input logic [31:0] a, input logic [31:0] d, input logic [31:0] m);
        set_req(i, 1'b1, a, d, m);
        step();
        set_req(i, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h5555_5555);
    endtask

    task automatic check_reset_outputs(input int i, input string tag);
        check1({tag, "_rdy"}, rdy[i], 1'b0);
        check1({tag, "_en"}, men[i], 1'b0);
        check1({tag, "_we"}, mwe[i], 1'b0);
        check({tag, "_addr"}, maddr[i], 32'h0);
        check({tag, "_wdat"}, mwdat[i], 32'h0);
        check1({tag, "_busy"}, busy[i], 1'b0);
        check1({tag, "_done"}, done[i], 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        for (int i = 0; i < 2; i++) set_req(i, 1'b0, 32'h0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs(0, "reset_u0");
        check_reset_outputs(1, "reset_u1");
        rst = 1'b0;
        step();
        check1("post_reset_rdy_u0", rdy[0], 1'b1);
        check1("post_reset_rdy_u1", rdy[1], 1'b1);

        // Full mask: straight write in T+1.
        t = cyc;
        exp_acc(0, t);
        exp_mem(0, t + 1, 1'b1, 32'd5, 32'h1234_5678);
        exp_done(0, t + 1);
        send(0, 32'd5, 32'h1234_5678, 32'hFFFF_FFFF);
        check1("full_busy_t1", busy[0], 1'b1);
        step();
        check1("full_rdy_t2", rdy[0], 1'b1);

        // Byte-lane RMW: read T+1, write merged data T+3.
        t = cyc;
        exp_acc(0, t);
        exp_mem(0, t + 1, 1'b0, 32'd3, 32'h0);
        exp_mem(0, t + 3, 1'b1, 32'd3, 32'h1122_AB44);
        exp_done(0, t + 3);
        send(0, 32'd3, 32'h0000_AB00, 32'h0000_FF00);
        check1("rmw_busy_t1", busy[0], 1'b1);
        step();
        check1("rmw_busy_t2", busy[0], 1'b1);
        step();
        check1("rmw_busy_t3", busy[0], 1'b1);
        step();
        check1("rmw_rdy_t4", rdy[0], 1'b1);
        check1("rmw_busy_t4", busy[0], 1'b0);

        // Empty mask: no memory access, done in T+1.
        t = cyc;
        exp_acc(0, t);
        exp_done(0, t + 1);
        send(0, 32'd7, 32'hFFFF_FFFF, 32'h0000_0000);
        step();
        check1("skip_rdy_t2", rdy[0], 1'b1);

        // Inverted polarity, RD_LATENCY=3: low halfword active.
        t = cyc;
        exp_acc(1, t);
        exp_mem(1, t + 1, 1'b0, 32'd9, 32'h0);
        exp_mem(1, t + 5, 1'b1, 32'd9, 32'hCAFE_BEEF);
        exp_done(1, t + 5);
        send(1, 32'd9, 32'h0000_BEEF, 32'hFFFF_0000);
        repeat (4) step();
        check1("lat3_rdy_t5", rdy[1], 1'b0);
        step();
        check1("lat3_rdy_t6", rdy[1], 1'b1);

        // Inverted polarity: all-zero mask is a full write, all-ones is dropped.
        t = cyc;
        exp_acc(1, t);
        exp_mem(1, t + 1, 1'b1, 32'd10, 32'hA5A5_A5A5);
        exp_done(1, t + 1);
        send(1, 32'd10, 32'hA5A5_A5A5, 32'h0000_0000);
        step();
        t = cyc;
        exp_acc(1, t);
        exp_done(1, t + 1);
        send(1, 32'd11, 32'h1111_1111, 32'hFFFF_FFFF);
        step();

        // Back-to-back with valid held high: accepts at T, T+2, T+6.
        t = cyc;
        exp_acc(0, t);
        exp_mem(0, t + 1, 1'b1, 32'd1, 32'hAAAA_0001);
        exp_done(0, t + 1);
        exp_acc(0, t + 2);
        exp_mem(0, t + 3, 1'b0, 32'd2, 32'h0);
        exp_mem(0, t + 5, 1'b1, 32'd2, 32'h5566_77CC);
        exp_done(0, t + 5);
        exp_acc(0, t + 6);
        exp_done(0, t + 7);
        set_req(0, 1'b1, 32'd1, 32'hAAAA_0001, 32'hFFFF_FFFF);
        step();
        set_req(0, 1'b1, 32'd2, 32'h0000_00CC, 32'h0000_00FF);
        step();
        step();
        set_req(0, 1'b1, 32'd4, 32'h0000_0000, 32'h0000_0000);
        repeat (4) step();
        set_req(0, 1'b0, 32'h0, 32'h0, 32'h0);
        step();

        // Async reset mid-WAIT: outputs drop at once, no write-back.
        t = cyc;
        exp_acc(0, t);
        exp_mem(0, t + 1, 1'b0, 32'd6, 32'h0);
        send(0, 32'd6, 32'hFFFF_FFFF, 32'h0000_00FF);
        step();
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs(0, "midwait_rst");
        @(posedge clk);
        #3;
        rst = 1'b0;
        step();
        check1("after_rst_rdy", rdy[0], 1'b1);
        check1("after_rst_busy", busy[0], 1'b0);
        t = cyc;
        exp_acc(0, t);
        exp_mem(0, t + 1, 1'b1, 32'd6, 32'h1357_9BDF);
        exp_done(0, t + 1);
        send(0, 32'd6, 32'h1357_9BDF, 32'hFFFF_FFFF);
        repeat (3) step();

        check("left_acc", 32'(q_acc.size()), 32'h0);
        check("left_mem", 32'(q_mem.size()), 32'h0);
        check("left_done", 32'(q_done.size()), 32'h0);
        check("mem0_3", mem0[3], 32'h1122_AB44);
        check("mem0_2", mem0[2], 32'h5566_77CC);
        check("mem0_7", mem0[7], 32'hA000_0007);
        check("mem0_4", mem0[4], 32'hA000_0004);
        check("mem0_6", mem0[6], 32'h1357_9BDF);
        check("mem1_9", mem1[9], 32'hCAFE_BEEF);
        check("mem1_10", mem1[10], 32'hA5A5_A5A5);
        check("mem1_11", mem1[11], 32'hB000_000B);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/zion_rmw_write_ctrl.md
Name: zion_rmw_write_ctrl

Overview:
Read-modify-write controller that sits directly downstream of the write-mask generator. It accepts one masked write request at a time: a word address, write data, and a per-bit mask in the generator's output format. It drives a single-port memory that has no byte enables. Full-mask writes go straight to memory, empty-mask writes are dropped, and partial masks become a read, a merge, and a write-back.

Parameters:
WIDTH_ADDR, 32, width of the word address passed through to memory
WIDTH_DATA, 32, data width; also the mask width (one mask bit per data bit)
MASK_FLAG, 0, mask polarity: 0 means mask bit 1 = write this bit; 1 means mask bit 0 = write this bit (same meaning as the generator's MASK_FLAG)
RD_LATENCY, 1, memory read latency in cycles; legal range 1..4

Ports:
iClk  in  1  clock
iRst  in  1  asynchronous reset, active-high
iReqVld  in  1  write request valid
oReqRdy  out  1  controller can accept a request
iReqAddr  in  WIDTH_ADDR  word address
iReqDat  in  WIDTH_DATA  write data, already lane-aligned
iReqMask  in  WIDTH_DATA  bit mask from the write-mask generator
oMemEn  out  1  memory access strobe
oMemWe  out  1  1 = write, 0 = read (meaningful only while oMemEn=1)
oMemAddr  out  WIDTH_ADDR  memory address
oMemWDat  out  WIDTH_DATA  memory write data
iMemRDat  in  WIDTH_DATA  memory read data, valid RD_LATENCY cycles after the read strobe
oBusy  out  1  a request is in flight (state != IDLE)
oDone  out  1  one-cycle pulse: the current request has completed

Behaviour:
- Reset (async, iRst=1): state=IDLE; all capture registers and the latency counter cleared. Outputs while in reset: oReqRdy=0, oMemEn=0, oMemWe=0, oMemAddr=0, oMemWDat=0, oBusy=0, oDone=0.
- After reset release: oReqRdy=1 in IDLE.
- Effective mask: m = MASK_FLAG ? ~iReqMask : iReqMask. Only m is stored.
- Handshake: oReqRdy = (state==IDLE), decoded from the state register. A request is accepted when iReqVld & oReqRdy. At acceptance, addr, dat and m are captured. Only one request is ever outstanding. iReqVld held high across a busy period is accepted again in the first IDLE cycle.
- States: IDLE, RD, WAIT, WR, SKIP. All memory outputs are decoded from registered state and captured values only, with no combinational path from request inputs.
- IDLE, on accept:
  - m == all ones -> WR
  - m == 0 -> SKIP
  - otherwise -> RD
  - no accept -> stay in IDLE
- RD: oMemEn=1, oMemWe=0, oMemAddr=captured addr. Load the latency counter with RD_LATENCY-1, then -> WAIT.
- WAIT: oMemEn=0.
  - While the counter != 0, decrement it and stay.
  - When the counter == 0, iMemRDat is valid this cycle. Register merged = (iMemRDat & ~m) | (dat & m), then -> WR.
- WR: oMemEn=1, oMemWe=1, oMemAddr=captured addr, oDone=1. Write data:
  - full mask: oMemWDat=dat
  - RMW path: oMemWDat=merged
  - next state -> IDLE
- SKIP: no memory access, oDone=1, -> IDLE.
- oMemAddr and oMemWDat read 0 whenever oMemEn=0 (no stale values on the bus).
- Latency, with acceptance in cycle T:
  - full mask: WR in T+1
  - empty mask: SKIP in T+1
  - RMW: RD in T+1, WAIT over T+2..T+1+RD_LATENCY, WR in T+2+RD_LATENCY
  - next acceptance possible: T+2 for full/empty, T+3+RD_LATENCY for RMW
- Request inputs may change freely after acceptance; the captured values are used.
- Reset during RD/WAIT: no write is issued and the request is lost. The memory may have performed a read, which has no side effect.
- Reset during WR: async clear; whether the memory sampled the write that cycle is outside this block's responsibility.
- RD_LATENCY outside 1..4: elaboration error ($fatal in an initial/generate check).

Test Plan:
- MASK_FLAG=0, RD_LATENCY=1. Accept at T with addr=5, dat=0x12345678, mask=0xFFFFFFFF -> at T+1 oMemEn=1, oMemWe=1, oMemAddr=5, oMemWDat=0x12345678, oDone=1; oReqRdy=1 at T+2; no read issued.
- MASK_FLAG=0, RD_LATENCY=1. Byte-lane write: addr=3, dat=0x0000AB00, mask=0x0000FF00, memory returns 0x11223344 -> read at T+1, write at T+3 with oMemWDat=0x1122AB44, oDone=1 at T+3, oBusy=1 over T+1..T+3.
- MASK_FLAG=0, RD_LATENCY=1. mask=0 -> oMemEn stays 0 throughout; oDone=1 at T+1; oReqRdy=1 at T+2.
- MASK_FLAG=1, RD_LATENCY=3. iReqMask=0xFFFF0000 (low halfword is the active lane), dat=0x0000BEEF, memory returns 0xCAFE0000 three cycles after the read -> WR at T+5 with oMemWDat=0xCAFEBEEF.
- Back-to-back: iReqVld held high for three requests (full, RMW, empty) -> accepts occur only while oReqRdy=1, at T, T+2 and T+6 (RD_LATENCY=1); exactly two memory writes and three oDone pulses.
- Reset asserted asynchronously mid-WAIT -> all outputs drop to 0 immediately; no write is issued; oReqRdy=1 in the first cycle after release and a new request completes normally.
